// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback arbiter.
// Optional build macro WB_ZERO_DROP_EN is interpreted in wb_rr_picker.
package wb_pkg;

  localparam int NUM_REQ = 4;
  localparam int NUM_WR  = 3;
  localparam int REG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int PORT_W  = $clog2(NUM_WR + 1);

  typedef struct packed {
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic int next_ptr(input int last, input int n);
    return (last + 1) % n;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: requester valid/ready handshake plus the three
// register-file write ports driven by the arbiter.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int NUM_REQ = wb_pkg::NUM_REQ
) ();

  logic                             wb_stall;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][REG_W-1:0]    req_reg;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]               req_ready;

  logic [REG_W-1:0]                 wr_reg1;
  logic [REG_W-1:0]                 wr_reg2;
  logic [REG_W-1:0]                 wr_reg3;
  logic                             wren_reg1;
  logic                             wren_reg2;
  logic                             wren_reg3;
  logic [DATA_W-1:0]                wr_d1;
  logic [DATA_W-1:0]                wr_d2;
  logic [DATA_W-1:0]                wr_d3;

  modport master (
    output wb_stall, req_valid, req_reg, req_data,
    input  req_ready,
    input  wr_reg1, wr_reg2, wr_reg3,
    input  wren_reg1, wren_reg2, wren_reg3,
    input  wr_d1, wr_d2, wr_d3
  );

  modport slave (
    input  wb_stall, req_valid, req_reg, req_data,
    output req_ready,
    output wr_reg1, wr_reg2, wr_reg3,
    output wren_reg1, wren_reg2, wren_reg3,
    output wr_d1, wr_d2, wr_d3
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Rotating-priority scan that grants up to NUM_WR writers per cycle.
// WB_ZERO_DROP_EN: register-0 requests are acknowledged without using a port.
module wb_rr_picker
  import wb_pkg::*;
#(
  parameter int NUM_REQ = wb_pkg::NUM_REQ,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [NUM_REQ-1:0]             elig,
  input  logic [NUM_REQ-1:0][REG_W-1:0]  regs,
  input  logic [PTR_W-1:0]               rr_ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_WR-1:0]              port_vld,
  output logic [NUM_WR-1:0][PTR_W-1:0]   port_sel,
  output logic                           any_grant,
  output logic [PTR_W-1:0]               last_idx
);

  // Scan from rr_ptr; a later request hitting an already-granted nonzero
  // destination waits, so two ports never write the same register at once.
  always_comb begin
    logic [NUM_REQ-1:0]           grant_v;
    logic [NUM_WR-1:0]            vld_v;
    logic [NUM_WR-1:0][PTR_W-1:0] sel_v;
    logic [PTR_W-1:0]             idx_v;
    logic [PTR_W-1:0]             last_v;
    logic [PORT_W-1:0]            used_v;
    logic                         any_v;
    logic                         zero_v;
    logic                         clash_v;
    logic                         drop_v;
    logic                         take_v;
    grant_v = {NUM_REQ{1'b0}};
    vld_v   = {NUM_WR{1'b0}};
    sel_v   = {(NUM_WR*PTR_W){1'b0}};
    idx_v   = {PTR_W{1'b0}};
    last_v  = {PTR_W{1'b0}};
    used_v  = {PORT_W{1'b0}};
    any_v   = 1'b0;
    zero_v  = 1'b0;
    clash_v = 1'b0;
    drop_v  = 1'b0;
    take_v  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_v   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      zero_v  = (regs[idx_v] == {REG_W{1'b0}});
      clash_v = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
        clash_v = clash_v | (grant_v[j] & ~zero_v & (regs[j] == regs[idx_v]));
      end
`ifdef WB_ZERO_DROP_EN
      drop_v = zero_v;
`else
      drop_v = 1'b0;
`endif
      take_v = valid[idx_v] & elig[idx_v] & ~clash_v &
               (drop_v | (used_v < PORT_W'(NUM_WR)));
      grant_v[idx_v] = take_v;
      any_v  = any_v | take_v;
      last_v = take_v ? idx_v : last_v;
      if (take_v && !drop_v) begin
        vld_v[used_v] = 1'b1;
        sel_v[used_v] = idx_v;
        used_v        = used_v + PORT_W'(1);
      end else begin
        used_v = used_v;
      end
    end
    grant     = grant_v;
    port_vld  = vld_v;
    port_sel  = sel_v;
    any_grant = any_v;
    last_idx  = last_v;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grants onto three registered register-file
// write ports. Build option WB_ZERO_DROP_EN (see wb_rr_picker).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REQ = wb_pkg::NUM_REQ
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              rr_ptr_r;
  logic [NUM_REQ-1:0]            elig_s;
  logic [NUM_REQ-1:0]            grant_s;
  logic [NUM_WR-1:0]             port_vld_s;
  logic [NUM_WR-1:0][PTR_W-1:0]  port_sel_s;
  logic                          any_grant_s;
  logic [PTR_W-1:0]              last_idx_s;
  logic [NUM_WR-1:0]             wren_r;
  wb_req_t [NUM_WR-1:0]          port_r;

  // Nothing is eligible while in reset or while the writeback stage stalls.
  assign elig_s = (rst_n && !bus.wb_stall) ? {NUM_REQ{1'b1}} : {NUM_REQ{1'b0}};

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid     (bus.req_valid),
    .elig      (elig_s),
    .regs      (bus.req_reg),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .port_vld  (port_vld_s),
    .port_sel  (port_sel_s),
    .any_grant (any_grant_s),
    .last_idx  (last_idx_s)
  );

  assign bus.req_ready = grant_s;

  // Capture granted writes; index/data hold when a port is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= {PTR_W{1'b0}};
      wren_r   <= {NUM_WR{1'b0}};
      port_r   <= {(NUM_WR*(REG_W+DATA_W)){1'b0}};
    end else begin
      wren_r <= port_vld_s;
      if (any_grant_s) begin
        rr_ptr_r <= PTR_W'(next_ptr(int'(last_idx_s), NUM_REQ));
      end
      for (int p = 0; p < NUM_WR; p++) begin
        if (port_vld_s[p]) begin
          port_r[p].reg_idx <= bus.req_reg[port_sel_s[p]];
          port_r[p].data    <= bus.req_data[port_sel_s[p]];
        end
      end
    end
  end

  assign bus.wren_reg1 = wren_r[0];
  assign bus.wren_reg2 = wren_r[1];
  assign bus.wren_reg3 = wren_r[2];
  assign bus.wr_reg1   = port_r[0].reg_idx;
  assign bus.wr_reg2   = port_r[1].reg_idx;
  assign bus.wr_reg3   = port_r[2].reg_idx;
  assign bus.wr_d1     = port_r[0].data;
  assign bus.wr_d2     = port_r[1].data;
  assign bus.wr_d3     = port_r[2].data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (default build or WB_ZERO_DROP_EN).
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic             stall;
    logic [3:0]       valid;
    logic [3:0][5:0]  regs;
    logic [3:0][31:0] data;
    logic [3:0]       exp_ready;
    logic [2:0]       exp_wren;
    logic [2:0][5:0]  exp_reg;
    logic [2:0][31:0] exp_d;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic stall, input logic [3:0] valid,
                              input logic [23:0] regs, input logic [127:0] data,
                              input logic [3:0] rdy, input logic [2:0] wren,
                              input logic [17:0] er, input logic [95:0] ed);
    vec_t v;
    v.stall = stall; v.valid = valid; v.regs = regs; v.data = data;
    v.exp_ready = rdy; v.exp_wren = wren; v.exp_reg = er; v.exp_d = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [2:0] act_wren();
    return {bus.wren_reg3, bus.wren_reg2, bus.wren_reg1};
  endfunction

  function automatic logic [17:0] act_regs();
    return {bus.wr_reg3, bus.wr_reg2, bus.wr_reg1};
  endfunction

  function automatic logic [95:0] act_data();
    return {bus.wr_d3, bus.wr_d2, bus.wr_d1};
  endfunction

  task automatic drive(input logic stall, input logic [3:0] valid,
                       input logic [23:0] regs, input logic [127:0] data);
    bus.wb_stall  = stall;
    bus.req_valid = valid;
    bus.req_reg   = regs;
    bus.req_data  = data;
  endtask

  initial begin
    logic [2:0][5:0]  ar;
    logic [2:0][31:0] ad;

    // rr_ptr walk through the table: 0 -> 3 -> 0 -> 1 -> 2 -> 2(stall) -> 2 -> 2 -> 3 -> 3 -> 1 -> 3
    vecs[0] = mk(1'b0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                 4'b0111, 3'b111, {6'd7, 6'd6, 6'd5}, {32'hA2, 32'hA1, 32'hA0});
    vecs[1] = mk(1'b0, 4'b1000, {6'd8, 18'd0}, {32'hA3, 96'd0},
                 4'b1000, 3'b001, {12'd0, 6'd8}, {64'd0, 32'hA3});
    vecs[2] = mk(1'b0, 4'b0011, {12'd0, 6'd9, 6'd9}, {64'd0, 32'hB, 32'hA},
                 4'b0001, 3'b001, {12'd0, 6'd9}, {64'd0, 32'hA});
    vecs[3] = mk(1'b0, 4'b0010, {12'd0, 6'd9, 6'd0}, {64'd0, 32'hB, 32'd0},
                 4'b0010, 3'b001, {12'd0, 6'd9}, {64'd0, 32'hB});
    vecs[4] = mk(1'b1, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, {32'd0, 32'h13, 32'h12, 32'h11},
                 4'b0000, 3'b000, 18'd0, 96'd0);
    vecs[5] = mk(1'b0, 4'b0111, {6'd0, 6'd3, 6'd2, 6'd1}, {32'd0, 32'h13, 32'h12, 32'h11},
                 4'b0111, 3'b111, {6'd2, 6'd1, 6'd3}, {32'h12, 32'h11, 32'h13});
    vecs[6] = mk(1'b0, 4'b0000, 24'd0, 128'd0, 4'b0000, 3'b000, 18'd0, 96'd0);
`ifdef WB_ZERO_DROP_EN
    vecs[7] = mk(1'b0, 4'b0100, 24'd0, {32'd0, 32'h77, 64'd0},
                 4'b0100, 3'b000, 18'd0, 96'd0);
`else
    vecs[7] = mk(1'b0, 4'b0100, 24'd0, {32'd0, 32'h77, 64'd0},
                 4'b0100, 3'b001, 18'd0, {64'd0, 32'h77});
`endif
    vecs[8] = mk(1'b0, 4'b1111, {6'd4, 6'd11, 6'd10, 6'd4}, {32'h30, 32'h33, 32'h32, 32'h31},
                 4'b1110, 3'b111, {6'd11, 6'd10, 6'd4}, {32'h33, 32'h32, 32'h30});
    vecs[9] = mk(1'b0, 4'b0001, {18'd0, 6'd4}, {96'd0, 32'h31},
                 4'b0001, 3'b001, {12'd0, 6'd4}, {64'd0, 32'h31});
`ifdef WB_ZERO_DROP_EN
    vecs[10] = mk(1'b0, 4'b0110, 24'd0, {32'd0, 32'h41, 32'h40, 32'd0},
                  4'b0110, 3'b000, 18'd0, 96'd0);
`else
    vecs[10] = mk(1'b0, 4'b0110, 24'd0, {32'd0, 32'h41, 32'h40, 32'd0},
                  4'b0110, 3'b011, 18'd0, {32'd0, 32'h41, 32'h40});
`endif

    // Reset state, with requests already pending.
    drive(1'b0, 4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(posedge clk); #1;
    #2;
    check("reset ready", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    check("reset wren", 32'(act_wren()), 32'h0);
    check("reset wr_reg", 32'(act_regs()), 32'h0);
    check("reset wr_d1", bus.wr_d1, 32'h0);
    check("reset wr_d2", bus.wr_d2, 32'h0);
    check("reset wr_d3", bus.wr_d3, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 24'd0, 128'd0);
    @(posedge clk); #1;
    check("post reset wren", 32'(act_wren()), 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].valid, vecs[i].regs, vecs[i].data);
      #2;
      check($sformatf("v%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d wren", i), 32'(act_wren()), 32'(vecs[i].exp_wren));
      ar = act_regs();
      ad = act_data();
      for (int p = 0; p < 3; p++) begin
        if (vecs[i].exp_wren[p]) begin
          check($sformatf("v%0d wr_reg%0d", i, p + 1), 32'(ar[p]), 32'(vecs[i].exp_reg[p]));
          check($sformatf("v%0d wr_d%0d", i, p + 1), ad[p], vecs[i].exp_d[p]);
        end
      end
    end

    // Idle cycle keeps last index/data on the port (rr_ptr is 3 here).
    drive(1'b0, 4'b1000, {6'd12, 18'd0}, {32'h55, 96'd0});
    #2;
    check("hold ready", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #1;
    check("hold wren a", 32'(act_wren()), 32'h1);
    drive(1'b0, 4'b0000, 24'd0, 128'd0);
    @(posedge clk); #1;
    check("hold wren b", 32'(act_wren()), 32'h0);
    check("hold wr_reg1", 32'(bus.wr_reg1), 32'd12);
    check("hold wr_d1", bus.wr_d1, 32'h55);

    // Reset right after a 3-grant transfer: writes cleared and rr_ptr back to 0.
    drive(1'b0, 4'b1111, {6'd23, 6'd22, 6'd21, 6'd20}, {32'h63, 32'h62, 32'h61, 32'h60});
    #2;
    check("rst3 ready", 32'(bus.req_ready), 32'h7);
    @(posedge clk); #1;
    check("rst3 wren", 32'(act_wren()), 32'h7);
    rst_n = 1'b0;
    #2;
    check("rst ready low", 32'(bus.req_ready), 32'h0);
    @(posedge clk); #1;
    check("rst wren", 32'(act_wren()), 32'h0);
    check("rst wr_reg", 32'(act_regs()), 32'h0);
    check("rst wr_d1", bus.wr_d1, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 24'd0, 128'd0);
    @(posedge clk); #1;
    check("rst release wren", 32'(act_wren()), 32'h0);
    drive(1'b0, 4'b1111, {6'd23, 6'd22, 6'd21, 6'd20}, {32'h63, 32'h62, 32'h61, 32'h60});
    #2;
    check("rst ptr ready", 32'(bus.req_ready), 32'h7);
    @(posedge clk); #1;
    check("rst ptr wr_reg1", 32'(bus.wr_reg1), 32'd20);
    check("rst ptr wr_d3", bus.wr_d3, 32'h62);
    drive(1'b0, 4'b0000, 24'd0, 128'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
